// File: rtl/wingbutled_ctrl.sv
// wingbutled_ctrl: button/LED wing controller with synchronised,
// debounced buttons, press/release pulses and per-LED dimming.
//
// Ports:
//   clk         system clock (only clock)
//   rst_n       synchronous active-low reset
//   io          wing header; even pins drive LEDs, odd pins are
//               tri-stated and read as buttons (io[2i]=led ch,
//               io[2i+1]=btn ch, ch = N_CH-1-i)
//   led_duty    per-channel duty, channel k at [k*PWM_BITS +: PWM_BITS]
//   buttons     debounced button levels
//   btn_press   1-cycle pulse on debounced 0->1
//   btn_release 1-cycle pulse on debounced 1->0
//
// Build option: define WINGBUTLED_PWM_EN for PWM dimming; without it
// each LED is simply on when its duty is non-zero.

module wingbutled_ctrl #(
    parameter int N_CH         = 4,
    parameter int DEBOUNCE_CYC = 32000,
    parameter int PWM_BITS     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    inout  wire  [2*N_CH-1:0]        io,
    input  logic [N_CH*PWM_BITS-1:0] led_duty,
    output logic [N_CH-1:0]          buttons,
    output logic [N_CH-1:0]          btn_press,
    output logic [N_CH-1:0]          btn_release
);

    localparam int cnt_w = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [cnt_w-1:0] cnt_max = cnt_w'(DEBOUNCE_CYC - 1);

    logic [N_CH-1:0]  pin_raw;
    logic [N_CH-1:0]  sync1;
    logic [N_CH-1:0]  sync2;
    logic [N_CH-1:0]  stable;
    logic [cnt_w-1:0] cnt [N_CH];
    logic [N_CH-1:0]  led_q;

    // Header pin map: pairs are laid out in reverse channel order.
    for (genvar i = 0; i < N_CH; i++) begin : g_pins
        assign io[2*i]             = led_q[N_CH-1-i];
        assign io[2*i+1]           = 1'bz;
        assign pin_raw[N_CH-1-i]   = io[2*i+1];
    end

    // Two-flop synchroniser on the raw button pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin_raw;
            sync2 <= sync1;
        end
    end

    // Debounce: the counter runs only while the synced level differs
    // from the accepted one, so any bounce back clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable      <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int c = 0; c < N_CH; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                btn_press[c]   <= 1'b0;
                btn_release[c] <= 1'b0;
                if (sync2[c] == stable[c]) begin
                    cnt[c] <= '0;
                end else if (cnt[c] == cnt_max) begin
                    stable[c]      <= sync2[c];
                    cnt[c]         <= '0;
                    btn_press[c]   <= sync2[c];
                    btn_release[c] <= ~sync2[c];
                end else begin
                    cnt[c] <= cnt[c] + 1'b1;
                end
            end
        end
    end

    assign buttons = stable;

`ifdef WINGBUTLED_PWM_EN

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] shadow [N_CH];
    logic                period_end;

    assign period_end = &pwm_cnt;

    // Duty is latched only at the last count of a period so a
    // mid-period update never produces a runt pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            led_q   <= '0;
            for (int c = 0; c < N_CH; c++) begin
                shadow[c] <= '0;
            end
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                led_q[c] <= (pwm_cnt < shadow[c]);
                if (period_end) begin
                    shadow[c] <= led_duty[c*PWM_BITS +: PWM_BITS];
                end
            end
        end
    end

`else

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                led_q[c] <= |led_duty[c*PWM_BITS +: PWM_BITS];
            end
        end
    end

`endif

endmodule

// File: tb/tb_wingbutled_ctrl.sv
// tb_wingbutled_ctrl: directed and randomised checks of the wing
// controller against a history-based reference model.

module tb_wingbutled_ctrl;

    localparam int NCH  = 4;
    localparam int DB   = 4;
    localparam int PB   = 4;
    localparam int HMAX = 8192;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] btn_pin = '0;
    logic [15:0]    led_duty = '0;
    wire  [7:0]     io;
    logic [3:0]     buttons;
    logic [3:0]     btn_press;
    logic [3:0]     btn_release;

    int n_assert = 0;
    int n_fail   = 0;

    // Bench drives the button pins (odd header pins).
    assign io[7] = btn_pin[0];
    assign io[5] = btn_pin[1];
    assign io[3] = btn_pin[2];
    assign io[1] = btn_pin[3];

    wingbutled_ctrl #(
        .N_CH(NCH),
        .DEBOUNCE_CYC(DB),
        .PWM_BITS(PB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io(io),
        .led_duty(led_duty),
        .buttons(buttons),
        .btn_press(btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    // Reference history: reset flag and pin levels seen at each edge.
    bit       rh [HMAX];
    bit [3:0] ph [HMAX];
    int       e = 0;
    int       ksince = 0;
    bit [3:0] exp_btn = '0;
    bit [3:0] exp_press = '0;
    bit [3:0] exp_rel = '0;
    bit [3:0] exp_led = '0;
    int       shadow [NCH];

    function automatic logic [3:0] led_obs();
        return {io[0], io[2], io[4], io[6]};
    endfunction

    // Level presented to the debouncer at edge ed: the pin two edges
    // earlier, unless the synchroniser was cleared in between.
    function automatic bit sval(int ed, int ch);
        if (ed - 2 < 1) return 1'b0;
        if (rh[ed-1] || rh[ed-2]) return 1'b0;
        return ph[ed-2][ch];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_edge();
        int  ed;
        bit  ok;
        int  phase;
        e++;
        rh[e] = !rst_n;
        ph[e] = btn_pin;
        exp_press = '0;
        exp_rel   = '0;
        if (!rst_n) begin
            exp_btn = '0;
            exp_led = '0;
            ksince  = 0;
            for (int c = 0; c < NCH; c++) shadow[c] = 0;
        end else begin
            // New level accepted after DB consecutive reset-free
            // edges of it differing from the current level.
            for (int c = 0; c < NCH; c++) begin
                ok = 1'b1;
                for (int j = 0; j < DB; j++) begin
                    ed = e - j;
                    if (ed < 1 || rh[ed]) ok = 1'b0;
                    else if (sval(ed, c) == exp_btn[c]) ok = 1'b0;
                end
                if (ok) begin
                    exp_btn[c] = ~exp_btn[c];
                    exp_press[c] = exp_btn[c];
                    exp_rel[c]   = ~exp_btn[c];
                end
            end
            ksince++;
            phase = (ksince - 1) % (1 << PB);
            for (int c = 0; c < NCH; c++) begin
`ifdef WINGBUTLED_PWM_EN
                exp_led[c] = (phase < shadow[c]);
                if (phase == (1 << PB) - 1)
                    shadow[c] = int'(led_duty[c*PB +: PB]);
`else
                exp_led[c] = (led_duty[c*PB +: PB] != 0);
`endif
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("buttons", 32'(buttons), 32'(exp_btn));
        chk("btn_press", 32'(btn_press), 32'(exp_press));
        chk("btn_release", 32'(btn_release), 32'(exp_rel));
        chk("led_pins", 32'(led_obs()), 32'(exp_led));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n;
        int hi0;
        int hi3;
        int npress;
        bit found;

        rh[0] = 1'b1;
        for (int c = 0; c < NCH; c++) shadow[c] = 0;

        // 1: reset, then idle
        ticks(2);
        rst_n = 1'b1;
        ticks(3);
        chk("rst_buttons", 32'(buttons), 32'd0);
        chk("rst_leds", 32'(led_obs()), 32'd0);

        // 2: press and release on io[7]
        btn_pin[0] = 1'b1;
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (buttons[0]) begin
                found = 1'b1;
                n = i;
                chk("press_pulse", 32'(btn_press), 32'd1);
            end
        end
        chk("press_latency", 32'(n), 32'd6);
        ticks(3);
        btn_pin[0] = 1'b0;
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (btn_release != 4'b0) begin
                found = 1'b1;
                n = i;
                chk("release_pulse", 32'(btn_release), 32'd1);
            end
        end
        chk("release_latency", 32'(n), 32'd6);

        // 3: bounce on io[1] rejected, then a clean press
        begin
            bit [5:0] pat;
            pat = 6'b011011;
            npress = 0;
            for (int i = 0; i < 6; i++) begin
                btn_pin[3] = pat[i];
                tick();
                npress += int'(btn_press[3]);
            end
            btn_pin[3] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                npress += int'(btn_press[3]);
            end
            chk("bounce_level", 32'(buttons[3]), 32'd0);
            chk("bounce_pulses", 32'(npress), 32'd0);
            btn_pin[3] = 1'b1;
            for (int i = 0; i < 10; i++) begin
                tick();
                npress += int'(btn_press[3]);
            end
            chk("hold_level", 32'(buttons[3]), 32'd1);
            chk("hold_pulses", 32'(npress), 32'd1);
            btn_pin[3] = 1'b0;
            ticks(10);
        end

`ifdef WINGBUTLED_PWM_EN
        // 4: PWM widths, deferred update, duty 0
        led_duty[0 +: 4]  = 4'd4;
        led_duty[12 +: 4] = 4'd15;
        ticks(32);
        hi0 = 0;
        hi3 = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            hi0 += int'(io[6]);
            hi3 += int'(io[0]);
        end
        chk("pwm_ch0_width", 32'(hi0), 32'd8);
        chk("pwm_ch3_width", 32'(hi3), 32'd30);
        ticks(7);
        led_duty[0 +: 4] = 4'd8;
        ticks(40);
        led_duty[0 +: 4] = 4'd0;
        ticks(32);
        hi0 = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            hi0 += int'(io[6]);
        end
        chk("pwm_duty0", 32'(hi0), 32'd0);
`else
        // 5: direct LED drive
        led_duty[4 +: 4] = 4'd3;
        tick();
        chk("led1_on", 32'(io[4]), 32'd1);
        led_duty[4 +: 4] = 4'd0;
        tick();
        chk("led1_off", 32'(io[4]), 32'd0);
        hi0 = 0;
        hi3 = 0;
`endif
        led_duty = '0;
        ticks(20);

        // 6: reset mid-debounce on io[3], then simultaneous presses
        btn_pin[2] = 1'b1;
        ticks(4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        found = 1'b0;
        n = 0;
        npress = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            npress += int'(btn_press[2]);
            if (buttons[2]) begin
                found = 1'b1;
                n = i;
            end
        end
        chk("rst_restart_latency", 32'(n), 32'd6);
        chk("rst_restart_pulses", 32'(npress), 32'd1);
        btn_pin = '0;
        ticks(10);
        btn_pin[1] = 1'b1;
        btn_pin[2] = 1'b1;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (btn_press != 4'b0) begin
                found = 1'b1;
                chk("simul_press", 32'(btn_press), 32'b0110);
            end
        end
        chk("simul_seen", 32'(found), 32'd1);
        btn_pin = '0;
        ticks(10);

        // Randomised phase: calm and bouncy bursts, duty changes,
        // occasional resets.
        for (int blk = 0; blk < 25; blk++) begin
            int flip_rng;
            flip_rng = ($urandom_range(0, 1) == 1) ? 1 : 12;
            for (int i = 0; i < 40; i++) begin
                for (int c = 0; c < NCH; c++) begin
                    if ($urandom_range(0, flip_rng) == 0)
                        btn_pin[c] = ~btn_pin[c];
                end
                if ($urandom_range(0, 19) == 0)
                    led_duty[$urandom_range(0, 3)*4 +: 4] =
                        4'($urandom_range(0, 15));
                rst_n = ($urandom_range(0, 299) != 0);
                tick();
            end
        end
        rst_n = 1'b1;
        ticks(5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
